// File: rtl/message_buffer_pkg.sv
// Shared constants and FSM state encoding for the message buffer slice.
// Imported by the top-level buffer and by its testbench.
package message_buffer_pkg;

  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_EOL1 = 3'd3,
    ST_GAP2 = 3'd4,
    ST_EOL2 = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/msg_store.sv
// DEPTH x DATA_W character store: one synchronous write port and one
// combinational read port, kept separate so it can map onto distributed RAM.
module msg_store #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; the length register alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/message_buffer.sv
// Keyboard-to-UART message buffer: collects up to DEPTH characters, then on
// commit streams them through a tx_busy/new_tx_data handshake with optional LF/CR.
module message_buffer
  import message_buffer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 5,
  parameter int APPEND_EOL = 1,
  parameter int AUTO_SEND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              commit,
  output logic [DATA_W-1:0] tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [PTR_W-1:0]  msg_len,
  output logic              overflow,
  output logic              busy
);

  localparam int               ADDR_W  = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_msg_len, w_msg_len_nxt;
  logic [PTR_W-1:0]    r_rd_ptr, w_rd_ptr_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_nxt;
  logic                r_new_tx, w_new_tx_nxt;
  logic                r_wr_ready, w_wr_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_we;
  logic                w_do_commit;
  logic [DATA_W-1:0]   w_rd_data;

  msg_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_msg_len[ADDR_W-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rd_data)
  );

  // NOTE: every comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_msg_len_nxt  = r_msg_len;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_overflow_nxt = r_overflow;
    w_tx_data_nxt  = r_tx_data;
    w_new_tx_nxt   = 1'b0;
    w_we           = 1'b0;
    w_do_commit    = 1'b0;

    case (r_state)
      ST_FILL: begin
        if (wr_valid) begin
          if (r_wr_ready) begin
            w_we          = 1'b1;
            w_msg_len_nxt = r_msg_len + PTR_ONE;
          end else begin
            w_overflow_nxt = 1'b1;
          end
        end
        w_do_commit = commit ||
                      ((AUTO_SEND != 0) && w_we && (w_msg_len_nxt == DEPTH_P));
        // A write in the commit cycle is already counted in w_msg_len_nxt.
        if (w_do_commit) begin
          if (w_msg_len_nxt != '0) begin
            w_state_nxt    = ST_SEND;
            w_rd_ptr_nxt   = '0;
            w_overflow_nxt = 1'b0;
          end else if (APPEND_EOL != 0) begin
            w_state_nxt    = ST_EOL1;
            w_rd_ptr_nxt   = '0;
            w_overflow_nxt = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_data_nxt = w_rd_data;
          w_new_tx_nxt  = 1'b1;
          w_rd_ptr_nxt  = r_rd_ptr + PTR_ONE;
          w_state_nxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_rd_ptr < r_msg_len) begin
          w_state_nxt = ST_SEND;
        end else if (APPEND_EOL != 0) begin
          w_state_nxt = ST_EOL1;
        end else begin
          w_state_nxt   = ST_DONE;
          w_msg_len_nxt = '0;
        end
      end
      ST_EOL1: begin
        if (!tx_busy) begin
          w_tx_data_nxt = DATA_W'(CHAR_LF);
          w_new_tx_nxt  = 1'b1;
          w_state_nxt   = ST_GAP2;
        end
      end
      ST_GAP2: w_state_nxt = ST_EOL2;
      ST_EOL2: begin
        if (!tx_busy) begin
          w_tx_data_nxt = DATA_W'(CHAR_CR);
          w_new_tx_nxt  = 1'b1;
          w_state_nxt   = ST_DONE;
          w_msg_len_nxt = '0;
        end
      end
      ST_DONE: w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase

    w_wr_ready_nxt = (w_state_nxt == ST_FILL) && (w_msg_len_nxt < DEPTH_P);
    w_busy_nxt     = !(w_state_nxt inside {ST_FILL, ST_DONE});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_msg_len  <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
      r_new_tx   <= 1'b0;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_msg_len  <= w_msg_len_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_overflow <= w_overflow_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_new_tx   <= w_new_tx_nxt;
      r_wr_ready <= w_wr_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign wr_ready    = r_wr_ready;
  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;
  assign msg_len     = r_msg_len;
  assign overflow    = r_overflow;
  assign busy        = r_busy;

endmodule

// File: tb/tb_message_buffer.sv
// Self-checking bench for message_buffer: hand sequences for the corner cases,
// a table-driven overflow fill, and randomized messages against a queue model.
module tb_message_buffer;
  import message_buffer_pkg::*;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int PW     = 5;
  localparam int DEPTH2 = 4;
  localparam int PW2    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, commit, tx_busy;
  logic [DW-1:0] wr_data;
  logic          wr_ready, new_tx_data, overflow, busy;
  logic [DW-1:0] tx_data;
  logic [PW-1:0] msg_len;

  logic           wr_valid2, commit2, tx_busy2;
  logic [DW-1:0]  wr_data2;
  logic           wr_ready2, new_tx_data2, overflow2, busy2;
  logic [DW-1:0]  tx_data2;
  logic [PW2-1:0] msg_len2;

  always #5 clk = ~clk;

  message_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW), .APPEND_EOL(1), .AUTO_SEND(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .msg_len(msg_len),
    .overflow(overflow), .busy(busy)
  );

  // Second flavour: no terminator, auto-send when full.
  message_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH2), .PTR_W(PW2), .APPEND_EOL(0), .AUTO_SEND(1)
  ) dut2 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid2), .wr_data(wr_data2),
    .wr_ready(wr_ready2), .commit(commit2), .tx_data(tx_data2),
    .new_tx_data(new_tx_data2), .tx_busy(tx_busy2), .msg_len(msg_len2),
    .overflow(overflow2), .busy(busy2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int viol = 0;
  int last_strobe = -10;
  logic busy_prev = 1'b0;
  logic rand_busy = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] rx2_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe and police the handshake rules as they happen.
  always @(negedge clk) begin
    if (new_tx_data === 1'b1) begin
      rx_q.push_back(tx_data);
      rx_cyc.push_back(cyc);
      if (cyc - last_strobe < 2) viol++;
      if (busy_prev) viol++;
      last_strobe = cyc;
    end
    busy_prev = tx_busy;
    if (new_tx_data2 === 1'b1) rx2_q.push_back(tx_data2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_busy) tx_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic write_char(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(busy === 1'b0 && wr_ready === 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_ready"}, wr_ready, 1);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_rx(input string name);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  typedef struct {
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       commit;
    int         exp_wr_ready;
    int         exp_len;
    int         exp_ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int written;
    int c_commit;
    logic comb;
    logic [7:0] d;

    // Overflow fill table: 17 writes into a 16-deep buffer, then commit.
    for (int i = 0; i < 17; i++) begin
      tbl[i].wr_valid     = 1'b1;
      tbl[i].wr_data      = 8'h61 + 8'(i);
      tbl[i].commit       = 1'b0;
      tbl[i].exp_len      = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      tbl[i].exp_wr_ready = (i + 1 < DEPTH) ? 1 : 0;
      tbl[i].exp_ovf      = (i >= DEPTH) ? 1 : 0;
    end
    tbl[17] = '{wr_valid: 1'b0, wr_data: 8'h00, commit: 1'b1,
                exp_wr_ready: 0, exp_len: DEPTH, exp_ovf: 0};

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; commit = 1'b0; tx_busy = 1'b0;
    wr_valid2 = 1'b0; wr_data2 = '0; commit2 = 1'b0; tx_busy2 = 1'b0;
    repeat (3) tick();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_tx_data", tx_data, 0);
    check("rst_new_tx", new_tx_data, 0);
    check("rst_msg_len", msg_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // "HI" with EOL: four strobes two cycles apart.
    clear_rx();
    write_char(8'h48);
    write_char(8'h49);
    check("hi_len", msg_len, 2);
    do_commit();
    c_commit = cyc;
    check("hi_busy_after_commit", busy, 1);
    wait_idle("hi");
    exp_q = '{8'h48, 8'h49, CHAR_LF, CHAR_CR};
    check_rx("hi");
    if (rx_cyc.size() > 0) check("hi_first_latency", rx_cyc[0] - c_commit, 1);
    for (int i = 1; i < rx_cyc.size(); i++)
      check($sformatf("hi_spacing%0d", i), rx_cyc[i] - rx_cyc[i-1], 2);
    check("hi_len_end", msg_len, 0);

    // Table-driven overflow fill followed by commit.
    clear_rx();
    for (int i = 0; i < 18; i++) begin
      wr_valid = tbl[i].wr_valid;
      wr_data  = tbl[i].wr_data;
      commit   = tbl[i].commit;
      tick();
      check($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].exp_wr_ready);
      check($sformatf("tbl%0d_len", i), msg_len, tbl[i].exp_len);
      check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    wait_idle("ovf");
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(tbl[i].wr_data);
    exp_q.push_back(CHAR_LF);
    exp_q.push_back(CHAR_CR);
    check_rx("ovf");
    check("ovf_cleared", overflow, 0);

    // Empty commit: EOL only on dut, nothing on dut2.
    clear_rx();
    do_commit();
    wait_idle("empty");
    exp_q = '{CHAR_LF, CHAR_CR};
    check_rx("empty");
    commit2 = 1'b1;
    tick();
    commit2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("empty2_busy%0d", i), busy2, 0);
      tick();
    end
    check("empty2_strobes", rx2_q.size(), 0);

    // tx_busy stall after the first strobe.
    clear_rx();
    write_char(8'h31);
    write_char(CHAR_SPACE);
    write_char(8'h33);
    do_commit();
    k = 0;
    while (new_tx_data !== 1'b1 && k < 10) begin tick(); k++; end
    check("stall_first_strobe", new_tx_data, 1);
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), new_tx_data, 0);
    end
    tx_busy = 1'b0;
    tick();
    check("stall_resume_strobe", new_tx_data, 1);
    check("stall_resume_data", tx_data, 32'(CHAR_SPACE));
    wait_idle("stall");
    exp_q = '{8'h31, CHAR_SPACE, 8'h33, CHAR_LF, CHAR_CR};
    check_rx("stall");

    // Write and commit in the same cycle; writes during SEND are ignored.
    clear_rx();
    write_char(8'h41);
    write_char(8'h42);
    wr_valid = 1'b1; wr_data = 8'h41; commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'($urandom);
      tick();
      check($sformatf("aba_ready%0d", i), wr_ready, 0);
      check($sformatf("aba_ovf%0d", i), overflow, 0);
    end
    wr_valid = 1'b0;
    wait_idle("aba");
    exp_q = '{8'h41, 8'h42, 8'h41, CHAR_LF, CHAR_CR};
    check_rx("aba");
    check("aba_len_end", msg_len, 0);

    // Reset after the second strobe of a five-character message.
    clear_rx();
    for (int i = 0; i < 5; i++) write_char(8'h50 + 8'(i));
    do_commit();
    k = 0;
    n = 0;
    while (k < 2 && n < 20) begin
      tick();
      n++;
      if (new_tx_data === 1'b1) k++;
    end
    check("rst_mid_strobes_seen", k, 2);
    rst = 1'b1;
    tick();
    check("rst_mid_new_tx", new_tx_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_len", msg_len, 0);
    check("rst_mid_ready", wr_ready, 1);
    check("rst_mid_tx_data", tx_data, 0);
    rst = 1'b0;
    repeat (20) tick();
    exp_q = '{8'h50, 8'h51};
    check_rx("rst_mid");

    // AUTO_SEND on dut2: filling to DEPTH2 transmits without commit or EOL.
    rx2_q.delete();
    for (int i = 0; i < DEPTH2; i++) begin
      wr_valid2 = 1'b1;
      wr_data2  = 8'h70 + 8'(i);
      tick();
    end
    wr_valid2 = 1'b0;
    check("auto_busy", busy2, 1);
    k = 0;
    while (!(busy2 === 1'b0 && wr_ready2 === 1'b1) && k < 100) begin tick(); k++; end
    check("auto_count", rx2_q.size(), DEPTH2);
    for (int i = 0; i < DEPTH2; i++)
      check($sformatf("auto_byte%0d", i),
            (i < rx2_q.size()) ? 32'(rx2_q[i]) : 32'hFFFF_FFFF, 32'h70 + i);
    check("auto_len_end", msg_len2, 0);
    check("auto_ovf", overflow2, 0);

    // Randomized messages against the queue model.
    rand_busy = 1'b1;
    for (int m = 0; m < 30; m++) begin
      clear_rx();
      n = $urandom_range(0, 20);
      comb = (n > 0) && ($urandom_range(0, 3) == 0);
      written = 0;
      for (int i = 0; i < n - (comb ? 1 : 0); i++) begin
        repeat ($urandom_range(0, 2)) tick();
        d = 8'($urandom);
        write_char(d);
        written++;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
      end
      check($sformatf("rnd%0d_len", m), msg_len, exp_q.size());
      check($sformatf("rnd%0d_ovf", m), overflow, (written > DEPTH) ? 1 : 0);
      if (comb) begin
        d = 8'($urandom);
        wr_valid = 1'b1; wr_data = d; commit = 1'b1;
        tick();
        wr_valid = 1'b0; commit = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
      end else begin
        do_commit();
      end
      exp_q.push_back(CHAR_LF);
      exp_q.push_back(CHAR_CR);
      wait_idle($sformatf("rnd%0d", m));
      check_rx($sformatf("rnd%0d", m));
      check($sformatf("rnd%0d_ovf_end", m), overflow, 0);
      check($sformatf("rnd%0d_len_end", m), msg_len, 0);
    end
    rand_busy = 1'b0;
    tx_busy   = 1'b0;
    tick();
    check("handshake_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
